// File: rtl/tcb_peri_gpio_seq_pkg.sv
// rtl/tcb_peri_gpio_seq_pkg.sv - shared types and register map for the GPIO command sequencer
package tcb_peri_gpio_seq_pkg;

  typedef enum logic [1:0] {
    OPC_WRITE = 2'd0,
    OPC_READ  = 2'd1,
    OPC_POLL  = 2'd2,
    OPC_DELAY = 2'd3
  } opc_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_RWT  = 3'd3,
    ST_CMP  = 3'd4,
    ST_DLY  = 3'd5,
    ST_RSP  = 3'd6
  } state_e;

  localparam logic [2:0] ADR_OE      = 3'd0;
  localparam logic [2:0] ADR_OD      = 3'd1;
  localparam logic [2:0] ADR_IE      = 3'd2;
  localparam logic [2:0] ADR_ID      = 3'd3;
  localparam logic [2:0] ADR_IRQ_ENA = 3'd4;
  localparam logic [2:0] ADR_IRQ_MOD = 3'd5;
  localparam logic [2:0] ADR_IRQ_POL = 3'd6;
  localparam logic [2:0] ADR_IRQ_STS = 3'd7;

endpackage

// File: rtl/tcb_peri_gpio_seq.sv
// rtl/tcb_peri_gpio_seq.sv - command-stream bus initiator for the tcb_peri_gpio register interface
// Runs WRITE/READ/POLL/DELAY commands; all bus and response outputs decode from registered state.
module tcb_peri_gpio_seq
  import tcb_peri_gpio_seq_pkg::*;
#(
  parameter int unsigned SYS_DAT = 32,
  parameter int unsigned SYS_RLT = 0,
  parameter int unsigned CNW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic [1:0]         cmd_opc,
  input  logic [2:0]         cmd_adr,
  input  logic [SYS_DAT-1:0] cmd_dat,
  input  logic [SYS_DAT-1:0] cmd_msk,
  input  logic [CNW-1:0]     cmd_cnt,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [SYS_DAT-1:0] rsp_dat,
  output logic               rsp_err,
  output logic               sys_wen,
  output logic [2:0]         sys_wad,
  output logic [SYS_DAT-1:0] sys_wdt,
  output logic               sys_ren,
  output logic [2:0]         sys_rad,
  input  logic [SYS_DAT-1:0] sys_rdt,
  output logic               busy
);

  state_e             state_q, state_d;
  opc_e               opc_q, opc_d;
  logic [2:0]         adr_q, adr_d;
  logic [SYS_DAT-1:0] dat_q, dat_d;
  logic [SYS_DAT-1:0] msk_q, msk_d;
  logic [SYS_DAT-1:0] rdt_q, rdt_d;
  logic [CNW-1:0]     lim_q, lim_d;
  logic [CNW-1:0]     cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               match;

  assign match = ((rdt_q ^ dat_q) & msk_q) == '0;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    msk_d   = msk_q;
    rdt_d   = rdt_q;
    lim_d   = lim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          opc_d = opc_e'(cmd_opc);
          adr_d = cmd_adr;
          dat_d = cmd_dat;
          msk_d = cmd_msk;
          lim_d = cmd_cnt;
          cnt_d = '0;
          err_d = 1'b0;
          unique case (opc_e'(cmd_opc))
            OPC_WRITE: state_d = ST_WR;
            OPC_READ:  state_d = ST_RD;
            OPC_POLL:  state_d = ST_RD;
            OPC_DELAY: state_d = (cmd_cnt == '0) ? ST_IDLE : ST_DLY;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR: state_d = ST_IDLE;
      ST_RD: begin
        if (SYS_RLT == 0) begin
          rdt_d   = sys_rdt;
          state_d = (opc_q == OPC_POLL) ? ST_CMP : ST_RSP;
        end else begin
          state_d = ST_RWT;
        end
      end
      ST_RWT: begin
        rdt_d   = sys_rdt;
        state_d = (opc_q == OPC_POLL) ? ST_CMP : ST_RSP;
      end
      ST_CMP: begin
        // cnt_q holds completed attempts minus one; lim_q extra attempts allowed
        if (match) begin
          state_d = ST_RSP;
        end else if (cnt_q == lim_q) begin
          err_d   = 1'b1;
          state_d = ST_RSP;
        end else begin
          cnt_d   = cnt_q + CNW'(1);
          state_d = ST_RD;
        end
      end
      ST_DLY: begin
        if (cnt_q == lim_q - CNW'(1)) state_d = ST_IDLE;
        else                          cnt_d   = cnt_q + CNW'(1);
      end
      ST_RSP: if (rsp_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opc_q   <= OPC_WRITE;
      adr_q   <= '0;
      dat_q   <= '0;
      msk_q   <= '0;
      rdt_q   <= '0;
      lim_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      msk_q   <= msk_d;
      rdt_q   <= rdt_d;
      lim_q   <= lim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cmd_rdy = (state_q == ST_IDLE);
  assign busy    = ~cmd_rdy;
  assign sys_wen = (state_q == ST_WR);
  assign sys_wad = sys_wen ? adr_q : '0;
  assign sys_wdt = sys_wen ? dat_q : '0;
  assign sys_ren = (state_q == ST_RD);
  assign sys_rad = sys_ren ? adr_q : '0;
  assign rsp_vld = (state_q == ST_RSP);
  assign rsp_dat = rsp_vld ? rdt_q : '0;
  assign rsp_err = rsp_vld & err_q;

endmodule
